// File: rtl/ps2_rx_buffered_if.sv
// Byte read port of the PS/2 receiver: show-ahead FIFO head plus pop strobe.
// The receiver drives the data side (master); the consumer drives rd_en (slave).
interface ps2_rx_buffered_if #(
   parameter int DEPTH = 8
);
   logic                      rd_en;
   logic [7:0]                data_out;
   logic                      data_valid;
   logic [$clog2(DEPTH):0]    fifo_count;

   modport master (
      input  rd_en,
      output data_out,
      output data_valid,
      output fifo_count
   );

   modport slave (
      output rd_en,
      input  data_out,
      input  data_valid,
      input  fifo_count
   );
endinterface

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: deglitched line sampling, 11-bit frame decode,
// show-ahead byte FIFO and a 7-segment history of the most recent bytes.
module ps2_rx_buffered #(
   parameter int FILTER_LEN     = 4,
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYC    = 5000,
   parameter int HEX_BYTES      = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ps2_clk,
   input  logic                      ps2_data,
   input  logic                      clr_err,
   ps2_rx_buffered_if.master         bus,
   output logic                      parity_err,
   output logic                      frame_err,
   output logic                      overflow,
   output logic [14*HEX_BYTES-1:0]   hex_out
);
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // index 0 = ps2_clk, index 1 = ps2_data
   logic [1:0] pin_in;
   logic [1:0] filt;
   assign pin_in = {ps2_data, ps2_clk};

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_filt
      logic          sync1_reg, sync2_reg, filt_reg;
      logic [FW-1:0] stab_cnt_reg;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            filt_reg     <= 1'b1;
            stab_cnt_reg <= '0;
         end else begin
            sync1_reg <= pin_in[gi];
            sync2_reg <= sync1_reg;
            if (sync2_reg == filt_reg) begin
               stab_cnt_reg <= '0;
            end else if (stab_cnt_reg == FW'(FILTER_LEN - 1)) begin
               filt_reg     <= sync2_reg;
               stab_cnt_reg <= '0;
            end else begin
               stab_cnt_reg <= stab_cnt_reg + FW'(1);
            end
         end
      end
      assign filt[gi] = filt_reg;
   end

   logic clk_filt_d_reg;
   logic fall, data_bit;
   assign fall     = clk_filt_d_reg & ~filt[0];
   assign data_bit = filt[1];

   state_t        state_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shreg_reg;
   logic          par_reg;
   logic [TW-1:0] tmo_cnt_reg;

   logic stop_fall, par_ok, accept, timeout;
   always_comb begin
      stop_fall = fall && (state_reg == STOP);
      par_ok    = ^{shreg_reg, par_reg};
      accept    = stop_fall && data_bit && par_ok;
      timeout   = (state_reg != IDLE) && !fall && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_filt_d_reg <= 1'b1;
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         shreg_reg      <= '0;
         par_reg        <= 1'b0;
         tmo_cnt_reg    <= '0;
         parity_err     <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         clk_filt_d_reg <= filt[0];
         parity_err     <= stop_fall && !par_ok;
         frame_err      <= (stop_fall && !data_bit) || timeout;
         if (state_reg == IDLE || fall) tmo_cnt_reg <= '0;
         else                           tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
         if (timeout) begin
            state_reg <= IDLE;
         end else if (fall) begin
            case (state_reg)
               IDLE: if (!data_bit) begin
                  state_reg   <= DATA;
                  bit_cnt_reg <= '0;
               end
               DATA: begin
                  shreg_reg   <= {data_bit, shreg_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
               end
               PARITY: begin
                  par_reg   <= data_bit;
                  state_reg <= STOP;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0] count;
   logic        full, pop, push_ok;
   always_comb begin
      count   = wr_ptr_reg - rd_ptr_reg;
      full    = (count == FULL_CNT);
      pop     = bus.rd_en && (count != '0);
      push_ok = accept && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= shreg_reg;
   end

   // a simultaneous pop frees the slot, so a push at full is only dropped without one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (accept && full && !pop) overflow <= 1'b1;
         else if (clr_err)           overflow <= 1'b0;
      end
   end

   assign bus.fifo_count = count;
   assign bus.data_valid = (count != '0);
   assign bus.data_out   = (count != '0) ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;

   logic [8*HEX_BYTES-1:0] hist_reg;
   logic [8*HEX_BYTES+7:0] hist_ext;
   assign hist_ext = {hist_reg, shreg_reg};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        hist_reg <= '0;
      else if (accept) hist_reg <= hist_ext[8*HEX_BYTES-1:0];
   end

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   // digit j shows nibble j of the history word, so byte k maps to digits 2k/2k+1
   for (gi = 0; gi < 2*HEX_BYTES; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = hist_reg[4*gi +: 4];
      assign hex_out[7*gi +: 7] = (SEG_ACTIVE_LOW != 0) ? ~seg7(nib) : seg7(nib);
   end
endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Bench for ps2_rx_buffered: directed frame table, corner-case sequences and
// randomized frames checked against a queue-based model of the receiver.
module tb_ps2_rx_buffered;
   localparam int FILTER_LEN  = 4;
   localparam int DEPTH       = 8;
   localparam int TIMEOUT_CYC = 400;
   localparam int HB          = 2;
   localparam int HALF        = 20;

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst, ps2_clk, ps2_data, clr_err;
   logic parity_err, frame_err, overflow;
   logic [14*HB-1:0] hex_out;

   ps2_rx_buffered_if #(.DEPTH(DEPTH)) bus ();

   ps2_rx_buffered #(
      .FILTER_LEN(FILTER_LEN), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC),
      .HEX_BYTES(HB), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .clr_err(clr_err), .bus(bus), .parity_err(parity_err),
      .frame_err(frame_err), .overflow(overflow), .hex_out(hex_out)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int pe_total = 0;
   int fe_total = 0;

   always @(negedge clk) begin
      if (parity_err) pe_total++;
      if (frame_err)  fe_total++;
   end

   // reference model
   logic [7:0] q[$];
   logic [7:0] m_hist [HB];
   logic       m_ovf;

   task automatic model_reset();
      q.delete();
      for (int k = 0; k < HB; k++) m_hist[k] = 8'h00;
      m_ovf = 1'b0;
   endtask

   function automatic logic [14*HB-1:0] exp_hex();
      logic [14*HB-1:0] e;
      e = '0;
      for (int k = 0; k < HB; k++) begin
         e[14*k +: 7]     = ~GLYPH[m_hist[k][3:0]];
         e[14*k + 7 +: 7] = ~GLYPH[m_hist[k][7:4]];
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, " fifo_count"}, 32'(bus.fifo_count), 32'(q.size()));
      chk({tag, " data_valid"}, 32'(bus.data_valid), 32'(q.size() != 0));
      chk({tag, " data_out"},   32'(bus.data_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
      chk({tag, " overflow"},   32'(overflow), 32'(m_ovf));
      chk({tag, " hex_out"},    32'(hex_out), 32'(exp_hex()));
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit,
                            input bit pop_at_last);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (HALF/2) @(negedge clk);
         if (i == glitch_bit) begin
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
         end
         repeat (HALF/2) @(negedge clk);
         ps2_clk = 1'b0;
         if (pop_at_last && i == nbits - 1) begin
            // rd_en lands on the edge that performs the push
            repeat (2 + FILTER_LEN) @(posedge clk);
            @(negedge clk);
            bus.rd_en = 1'b1;
            @(posedge clk);
            #1 bus.rd_en = 1'b0;
         end
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_bit, input bit pop_stop, input string tag,
                            output int dpe, output int dfe);
      int  pe0, fe0;
      bit  ok, accept;
      pe0 = pe_total;
      fe0 = fe_total;
      send_bits(mk(d, p, s), 11, glitch_bit, pop_stop);
      repeat (20) @(negedge clk);
      dpe = pe_total - pe0;
      dfe = fe_total - fe0;
      ok     = (($countones(d) + int'(p)) % 2) == 1;
      accept = s && ok;
      if (pop_stop && q.size() != 0) void'(q.pop_front());
      if (accept) begin
         for (int k = HB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = d;
         if (q.size() < DEPTH) q.push_back(d);
         else                  m_ovf = 1'b1;
      end
      chk({tag, " parity_err pulses"}, 32'(dpe), 32'(!ok));
      chk({tag, " frame_err pulses"},  32'(dfe), 32'(!s));
      check_state(tag);
   endtask

   task automatic do_pop(input string tag);
      @(negedge clk);
      bus.rd_en = 1'b1;
      @(posedge clk);
      #1 bus.rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      @(negedge clk);
      check_state(tag);
   endtask

   task automatic do_clr(input string tag);
      @(negedge clk);
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      m_ovf = 1'b0;
      @(negedge clk);
      check_state(tag);
   endtask

   typedef struct {
      logic [7:0]  data;
      logic        par;
      logic        stop;
      logic        pop;
      int          exp_pe;
      int          exp_fe;
      int          exp_cnt;
      logic [13:0] exp_hex0;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int dpe, dfe;
      logic [7:0] d;
      logic p, s;

      tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0, 1, {7'h79, 7'h46}};
      tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1, 0, 0, {7'h79, 7'h46}};
      tbl[2] = '{8'hAA, 1'b1, 1'b0, 1'b0, 0, 1, 0, {7'h79, 7'h46}};
      tbl[3] = '{8'hAA, 1'b1, 1'b1, 1'b1, 0, 0, 1, {7'h08, 7'h08}};
      tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 1, 0, {7'h08, 7'h08}};
      tbl[5] = '{8'hDB, 1'b1, 1'b1, 1'b1, 0, 0, 1, {7'h21, 7'h03}};
      tbl[6] = '{8'hE7, 1'b1, 1'b1, 1'b1, 0, 0, 1, {7'h06, 7'h78}};
      tbl[7] = '{8'hF0, 1'b1, 1'b1, 1'b1, 0, 0, 1, {7'h0E, 7'h40}};

      rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; clr_err = 1'b0; bus.rd_en = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      check_state("reset");
      chk("reset parity_err", 32'(parity_err), 32'h0);
      chk("reset frame_err", 32'(frame_err), 32'h0);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      // directed frame table
      for (int i = 0; i < 8; i++) begin
         run_frame(tbl[i].data, tbl[i].par, tbl[i].stop, -1, 1'b0, $sformatf("tbl%0d", i), dpe, dfe);
         chk($sformatf("tbl%0d pe", i), 32'(dpe), 32'(tbl[i].exp_pe));
         chk($sformatf("tbl%0d fe", i), 32'(dfe), 32'(tbl[i].exp_fe));
         chk($sformatf("tbl%0d count", i), 32'(bus.fifo_count), 32'(tbl[i].exp_cnt));
         chk($sformatf("tbl%0d hex0", i), 32'(hex_out[13:0]), 32'(tbl[i].exp_hex0));
         if (tbl[i].pop) do_pop($sformatf("tbl%0d pop", i));
      end

      // partial frame abandoned by timeout, then a clean frame
      begin
         int pe0, fe0;
         pe0 = pe_total; fe0 = fe_total;
         send_bits(mk(8'h5A, 1'b1, 1'b1), 5, -1, 1'b0);
         repeat (TIMEOUT_CYC + 40) @(negedge clk);
         chk("timeout frame_err pulses", 32'(fe_total - fe0), 32'h1);
         chk("timeout parity_err pulses", 32'(pe_total - pe0), 32'h0);
         check_state("timeout");
      end
      run_frame(8'hAA, 1'b1, 1'b1, -1, 1'b0, "after_timeout", dpe, dfe);
      chk("after_timeout data_out", 32'(bus.data_out), 32'hAA);
      do_pop("after_timeout pop");

      // glitches on ps2_clk while idle (data low) and mid-frame
      @(negedge clk);
      ps2_data = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      ps2_data = 1'b1;
      repeat (30) @(negedge clk);
      run_frame(8'h55, 1'b1, 1'b1, 3, 1'b0, "glitch", dpe, dfe);
      chk("glitch data_out", 32'(bus.data_out), 32'h55);
      do_pop("glitch pop");

      // fill past full
      for (int i = 1; i <= 9; i++)
         run_frame(8'(i), ~^8'(i), 1'b1, -1, 1'b0, $sformatf("fill%0d", i), dpe, dfe);
      chk("full count", 32'(bus.fifo_count), 32'(DEPTH));
      chk("full overflow", 32'(overflow), 32'h1);
      chk("full hex0", 32'(hex_out[13:0]), 32'({7'h40, 7'h10}));
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain%0d data_out", i), 32'(bus.data_out), 32'(i));
         do_pop($sformatf("drain%0d", i));
      end
      do_clr("clr_err");
      chk("clr overflow", 32'(overflow), 32'h0);

      // randomized frames with random pops
      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom_range(0, 255));
         p = ($urandom_range(0, 3) == 0) ? ^d : ~^d;
         s = ($urandom_range(0, 7) != 0);
         run_frame(d, p, s, -1, 1'b0, $sformatf("rand%0d", n), dpe, dfe);
         if ($urandom_range(0, 2) == 0) do_pop($sformatf("rand%0d pop", n));
      end

      // refill to full, then push and pop on the same edge
      while (q.size() < DEPTH) begin
         d = 8'($urandom_range(0, 255));
         run_frame(d, ~^d, 1'b1, -1, 1'b0, "refill", dpe, dfe);
      end
      if (m_ovf) do_clr("refill clr");
      run_frame(8'hC3, 1'b1, 1'b1, -1, 1'b1, "push_pop_full", dpe, dfe);
      chk("push_pop_full count", 32'(bus.fifo_count), 32'(DEPTH));
      chk("push_pop_full overflow", 32'(overflow), 32'h0);

      // reset in the middle of a frame
      send_bits(mk(8'h3C, 1'b1, 1'b1), 5, -1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_state("mid_reset");
      chk("mid_reset parity_err", 32'(parity_err), 32'h0);
      chk("mid_reset frame_err", 32'(frame_err), 32'h0);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      run_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0, "post_reset", dpe, dfe);
      chk("post_reset count", 32'(bus.fifo_count), 32'h1);
      chk("post_reset data_out", 32'(bus.data_out), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ps2_rx_buffered.md
Name: ps2_rx_buffered

Overview:
Parametrised PS/2 device-to-host receiver. It synchronises and deglitches the PS/2 clock and data lines, decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks parity, framing and inter-edge timeout. Accepted bytes go into a show-ahead FIFO with a read-enable handshake. The last HEX_BYTES accepted bytes are driven onto 7-segment digit outputs for the board display.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised samples required before filtered ps2 clock/data change (>=1)
DEPTH, 8, FIFO depth in bytes, power of 2, >=2
TIMEOUT_CYC, 5000, clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted
HEX_BYTES, 1, number of most recent bytes shown on hex_out (2 digits each)
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low, 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ps2_clk  in  1  PS/2 clock line, asynchronous
ps2_data  in  1  PS/2 data line, asynchronous
rd_en  in  1  pop FIFO head this cycle; ignored when data_valid=0
clr_err  in  1  clears sticky overflow
data_out  out  8  FIFO head byte (show-ahead); 0x00 when empty
data_valid  out  1  FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  bytes held
parity_err  out  1  one-cycle pulse: frame rejected for parity
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
overflow  out  1  sticky: good frame dropped because FIFO full
hex_out  out  14*HEX_BYTES  segments gfedcba; digit 2k = low nibble, digit 2k+1 = high nibble of byte k; byte 0 = newest

Behaviour:
- Reset (rst=0, async): synchronisers and filters load 1, FSM=IDLE, FIFO empty, fifo_count=0, data_valid=0, data_out=0, pulses=0, overflow=0, history bytes=0x00, so every digit shows glyph "0" (0x40 active-low, 0x3F active-high). A frame in progress is discarded.
- Input path: two-flop synchroniser per line, then a stability counter per line; the filtered value changes only after FILTER_LEN consecutive equal samples. A fall event is one cycle in which filtered clk goes 1->0. The data bit sampled is filtered data in that cycle.
- FSM, advancing only on fall events:
  IDLE: data=0 -> DATA, bitcnt=0; data=1 -> stay (spurious edge ignored).
  DATA: shift right into shreg (LSB first), bitcnt++; after the 8th bit -> PARITY.
  PARITY: store the bit -> STOP.
  STOP: evaluate -> IDLE. Odd parity is the XOR of 8 data bits and parity bit, which must equal 1.
    stop=1 and parity ok: accept byte.
    stop=1 and parity bad: parity_err pulse, no push.
    stop=0: frame_err pulse, and parity_err too if parity bad; no push.
- Timeout: the counter runs while FSM != IDLE and resets on every fall event. On reaching TIMEOUT_CYC: frame_err pulse, -> IDLE, partial data discarded. It stays 0 in IDLE.
- Latency: error pulses, FIFO push and history update are registered in the cycle after the stop-bit fall event. The fall event lags the pin by 2+FILTER_LEN clk.
- FIFO: circular buffer with wrapping pointers. A pop on rd_en && data_valid takes effect at the clock edge, and data_out shows the next entry the following cycle.
  Push while full without a simultaneous pop: byte dropped, overflow<=1.
  Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  Push when empty with rd_en=1: rd_en ignored, push accepted.
  clr_err clears overflow. If clr_err and a new overflow occur in the same cycle, the set wins.
- History: on every accepted byte (even if dropped by a full FIFO), byte k <= byte k-1 and byte 0 <= new byte. Hex decode is combinational from the history registers: standard 0-9, A, b, C, d, E, F glyphs. Outputs are inverted when SEG_ACTIVE_LOW=1.
- Pulses last exactly one clk. No outputs depend combinationally on ps2 pins.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a ~12 kHz ps2_clk -> one cycle after the stop fall: data_valid=1, data_out=0x1C, fifo_count=1, no error pulses, hex digit1="1" (0x79 active-low), digit0="C" (0x46); rd_en for 1 cycle -> data_valid=0, fifo_count=0.
- 0x1C sent with parity=1 -> parity_err high for exactly 1 cycle, fifo_count stays 0, hex unchanged. 0xAA with parity 1 and stop=0 -> frame_err pulse only.
- Clocking stops after 4 data bits, then wait TIMEOUT_CYC -> frame_err pulse, FSM IDLE. A following complete 0xAA frame (parity 1) -> data_out=0xAA.
- DEPTH=8: frames 0x01..0x09 with no reads -> fifo_count=8, overflow=1 after the 9th. Reads return 0x01..0x08 in order, and hex digit pair 0 shows "09". clr_err -> overflow=0. Push and pop in the same cycle at full -> count stays 8, overflow stays 0.
- Glitch: 2-cycle low pulse on ps2_clk with FILTER_LEN=4 while IDLE and during DATA -> no bit captured. The subsequent frame 0x55 is received intact.
- Assert rst mid-frame after 5 bits, release, then send 0x3C -> all outputs at reset values during reset. Afterwards exactly one byte 0x3C is received, with no error pulses.
